// File: rtl/dso_pkg.sv
// Shared DSO definitions: measurement FSM states
// and the default system clock rate.
package dso_pkg;

  localparam int DSO_CLK_FREQ = 50_000_000;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meas_state_e;

endpackage

// File: rtl/sync_edge.sv
// Synchronizes an asynchronous input and emits a
// one-cycle pulse on each rising edge.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_async,
  output logic rise_p
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_p <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
      prev_q <= sync_out;
      rise_p <= sync_out & ~prev_q;
    end
  end

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of sig_in over a one-second
// gate and publishes the count in Hz.
module freq_meter
  import dso_pkg::*;
#(
  parameter int CLK_FREQ    = DSO_CLK_FREQ,
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  sig_in,
  output logic [DATA_WIDTH-1:0] freq,
  output logic                  freq_vld,
  output logic                  ovf
);

  localparam int GW =
    (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [GW-1:0] GATE_LAST =
    GW'(CLK_FREQ - 1);
  localparam logic [DATA_WIDTH-1:0] CNT_MAX = '1;

  meas_state_e           state_q;
  meas_state_e           state_d;
  logic [GW-1:0]         gate_q;
  logic [DATA_WIDTH-1:0] edge_q;
  logic                  sat_q;
  logic                  edge_p;
  logic                  gate_end;
  logic                  edge_full;
  logic                  clr;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_async(sig_in),
    .rise_p (edge_p)
  );

  assign gate_end  = (state_q == MEASURE) &&
                     (gate_q == GATE_LAST);
  assign edge_full = (edge_q == CNT_MAX);
  // counters restart at gate end and whenever idle
  assign clr = (state_q == IDLE) ||
               (state_d == IDLE) || gate_end;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en)  state_d = MEASURE;
      MEASURE: if (!en) state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_q <= '0;
      edge_q <= '0;
      sat_q  <= 1'b0;
    end else if (clr) begin
      gate_q <= '0;
      edge_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      gate_q <= gate_q + GW'(1);
      if (edge_p) begin
        if (edge_full) sat_q  <= 1'b1;
        else           edge_q <= edge_q + DATA_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq     <= '0;
      freq_vld <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      freq_vld <= gate_end;
      if (gate_end) begin
        freq <= (edge_p && edge_full) ? CNT_MAX :
                edge_q + DATA_WIDTH'(edge_p);
        ovf  <= sat_q | (edge_p & edge_full);
      end
    end
  end

endmodule
